// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped countdown timer: FSM encoding,
// register byte offsets, CTRL bit positions and mode values.
package mmio_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [31:0] OFF_CTRL   = 32'h0;
  localparam logic [31:0] OFF_PRESET = 32'h4;
  localparam logic [31:0] OFF_COUNT  = 32'h8;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/mmio_timer.sv
// Countdown timer on the data-memory port: CTRL/PRESET/COUNT registers,
// reload/decrement FSM, interrupt logic included when TIMER_IRQ_EN is defined.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        irq
);

  state_e      state_q;
  logic        en_q;
  logic [1:0]  mode_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        im_rd;

  logic sel_ctrl, sel_pre, sel_cnt;
  logic wr_ctrl, wr_pre;
  logic unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign sel_ctrl = (addr[31:2] == BASE_ADDR[31:2] + OFF_CTRL[31:2]);
  assign sel_pre  = (addr[31:2] == BASE_ADDR[31:2] + OFF_PRESET[31:2]);
  assign sel_cnt  = (addr[31:2] == BASE_ADDR[31:2] + OFF_COUNT[31:2]);
  assign hit      = sel_ctrl | sel_pre | sel_cnt;

  assign wr_ctrl = we & sel_ctrl;
  assign wr_pre  = we & sel_pre;

  always_comb begin
    rd = '0;
    if (sel_ctrl) rd = {28'd0, im_rd, mode_q, en_q};
    if (sel_pre)  rd = preset_q;
    if (sel_cnt)  rd = count_q;
  end

`ifdef TIMER_IRQ_EN
  logic im_q, im_d;
  logic pending_q, pending_d;
  logic irq_q;

  // irq is registered from the next-state pending so it rises on the same
  // edge that enters INT rather than one cycle later.
  always_comb begin
    im_d      = wr_ctrl ? wd[CTRL_IM] : im_q;
    pending_d = pending_q;
    if (wr_ctrl)
      pending_d = 1'b0;
    else if (state_q == ST_CNT && en_q && count_q == 32'd0)
      pending_d = 1'b1;
    else if (state_q == ST_INT && mode_q == MODE_RELOAD)
      pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q      <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      im_q      <= im_d;
      pending_q <= pending_d;
      irq_q     <= pending_d & im_d;
    end
  end

  assign im_rd = im_q;
  assign irq   = irq_q;
`else
  assign im_rd = 1'b0;
  assign irq   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (en_q) state_q <= ST_LOAD;
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_q)                 state_q <= ST_IDLE;
          else if (count_q == 32'd0) state_q <= ST_INT;
          else                       count_q <= count_q - 32'd1;
        end
        ST_INT: begin
          if (mode_q == MODE_RELOAD) state_q <= ST_LOAD;
          else begin
            en_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
      endcase
      // Core write placed last so it overrides the FSM's EN auto-clear.
      if (wr_ctrl) begin
        en_q   <= wd[CTRL_EN];
        mode_q <= wd[CTRL_MODE +: 2];
      end
      if (wr_pre) preset_q <= wd;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: a formula-based timing model predicts
// rd/hit/irq each cycle; a negedge monitor pops and compares.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic        irq;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd),
    .rd(rd), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] rd;
    logic        hit;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Model of architectural state as seen after the most recent clock edge.
  logic [3:0]  m_ctrl;
  logic [31:0] m_pre;
  logic [31:0] m_cnt;
  logic        m_irq;

  // Count after edge N+kk, where N is the edge that set EN out of reset.
  function automatic int m_count(int kk, int p1, int p2, bit am);
    int j;
    if (kk < 2) return 0;
    j = kk - 2;
    if (!am || j < p1 + 3) return (j <= p1) ? p1 - j : 0;
    j = (j - p1 - 3) % (p2 + 3);
    return (j <= p2) ? p2 - j : 0;
  endfunction

  function automatic bit m_pend(int kk, int p1, int p2, bit am);
    int j;
    if (!am) return kk >= p1 + 3;
    if (kk < 2) return 1'b0;
    j = kk - 2;
    if (j < p1 + 3) return j == p1 + 1;
    return ((j - p1 - 3) % (p2 + 3)) == p2 + 1;
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    logic [31:0] off;
    off = {a[31:2], 2'b00} - BASE;
    if (off == 32'd0) return {28'd0, m_ctrl};
    if (off == 32'd4) return m_pre;
    if (off == 32'd8) return m_cnt;
    return 32'd0;
  endfunction

  function automatic logic exp_hit(logic [31:0] a);
    logic [31:0] off;
    off = {a[31:2], 2'b00} - BASE;
    return (off == 32'd0) || (off == 32'd4) || (off == 32'd8);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return BASE;
      1: return BASE + 32'd4;
      2: return BASE + 32'd8;
      3: return BASE + 32'd12;
      4: return BASE + 32'd9;
      default: return 32'h0000_1000;
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] r, input logic h, input logic i);
    exp_t e;
    e.a = a; e.rd = r; e.hit = h; e.irq = i;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; we = w; wd = d;
    push_exp(a, exp_rd(a), exp_hit(a), m_irq);
  endtask

  task automatic model_zero();
    m_ctrl = '0; m_pre = '0; m_cnt = '0; m_irq = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    we = 1'b0; reset = 1'b1;
    model_zero();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // kind: 0 plain run, 1 disable at edge tE, 2 rewrite PRESET to p2 at edge tE.
  task automatic run_scen(input int p1, input int m, input bit im, input int kind,
                          input int tE, input int p2, input int len, input bit clear);
    bit          am;
    logic [31:0] a, d, r;
    logic        w;
    int          pp2;
    am  = (m == 1);
    pp2 = (kind == 2) ? p2 : p1;
    step(BASE + 32'd4, 1'b1, 32'(p1));
    m_pre = 32'(p1);
    for (int t = 0; t < len; t++) begin
      r = $urandom();
      a = rand_addr(); w = 1'b0; d = r;
      if (t == 0) begin
        a = BASE; w = 1'b1; d = {r[31:4], im, 2'(m), 1'b1};
      end else if (kind == 1 && t == tE) begin
        a = BASE; w = 1'b1; d = {r[31:4], im, 2'(m), 1'b0};
      end else if (kind == 2 && t == tE) begin
        a = BASE + 32'd4; w = 1'b1; d = 32'(p2);
      end else if ($urandom_range(0, 3) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? BASE + 32'd8 : BASE + 32'd12;
        w = 1'b1;
      end
      step(a, w, d);
      if (kind == 1 && t >= tE) begin
        m_cnt  = 32'(m_count(tE, p1, pp2, am));
        m_irq  = 1'b0;
        m_ctrl = {im & IRQ_EN, 2'(m), 1'b0};
      end else begin
        m_cnt  = 32'(m_count(t, p1, pp2, am));
        m_irq  = IRQ_EN & im & m_pend(t, p1, pp2, am);
        m_ctrl = {im & IRQ_EN, 2'(m), am ? 1'b1 : (t < p1 + 4)};
      end
      if (kind == 2 && t >= tE) m_pre = 32'(p2);
    end
    if (clear) begin
      step(BASE, 1'b1, 32'd0);
      m_ctrl = '0; m_irq = 1'b0;
      step(BASE + 32'd8, 1'b0, 32'd0);
      step(BASE, 1'b0, 32'd0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd !== e.rd) begin
          failures++;
          $display("FAIL rd addr=%h got=%h exp=%h t=%0t", e.a, rd, e.rd, $time);
        end
        checks++;
        if (hit !== e.hit) begin
          failures++;
          $display("FAIL hit addr=%h got=%b exp=%b t=%0t", e.a, hit, e.hit, $time);
        end
        checks++;
        if (irq !== e.irq) begin
          failures++;
          $display("FAIL irq addr=%h got=%b exp=%b t=%0t", e.a, irq, e.irq, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p1, m, kind, tE, p2, len;
    bit im, am;
    reset = 1'b1; addr = '0; we = 1'b0; wd = '0;
    model_zero();
    // Registers read zero while reset is held, and the +12 slot misses.
    step(BASE, 1'b0, 32'd0);
    step(BASE + 32'd4, 1'b0, 32'd0);
    step(BASE + 32'd8, 1'b0, 32'd0);
    step(BASE + 32'd12, 1'b0, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    step(BASE + 32'd12, 1'b1, 32'hFFFF_FFFF);
    step(BASE, 1'b0, 32'd0);

    do_reset(); run_scen(5, 0, 1'b1, 0, 0, 5, 13, 1'b1);
    do_reset(); run_scen(2, 1, 1'b1, 0, 0, 2, 22, 1'b0);
    do_reset(); run_scen(6, 0, 1'b1, 1, 5, 6, 10, 1'b1);
    do_reset(); run_scen(4, 1, 1'b1, 2, 3, 9, 34, 1'b0);
    do_reset(); run_scen(0, 0, 1'b1, 0, 0, 0, 8, 1'b1);

    // Async reset while counting with COUNT at 4.
    do_reset(); run_scen(6, 1, 1'b1, 0, 0, 6, 5, 1'b0);
    @(posedge clk); #1;
    addr = BASE + 32'd8; we = 1'b0;
    push_exp(addr, 32'd0, 1'b1, 1'b0);
    #1 reset = 1'b1;
    model_zero();
    step(BASE, 1'b0, 32'd0);
    @(negedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) step(BASE + 32'd8, 1'b0, 32'd0);

    for (int it = 0; it < 12; it++) begin
      p1   = $urandom_range(0, 10);
      m    = $urandom_range(0, 3);
      im   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      tE   = $urandom_range(2, p1 + 2);
      p2   = $urandom_range(0, 12);
      am   = (m == 1);
      len  = am ? (2 + (p1 + 3) + 2 * (((kind == 2) ? p2 : p1) + 3) + 1) : (p1 + 8);
      do_reset();
      run_scen(p1, m, im, kind, tE, p2, len, !am || kind == 1);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
